charge_bay_arbiter: RTL
=======================

CHARGE_BAY_ARBITER -- requirements
Module: charge_bay_arbiter

Interface
REQ-001 Clk  input  1  system clock; all state changes on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 Tick  input  1  one-cycle charge-time tick (one time unit); ignored outside CHARGE.
REQ-004 Load  input  1  strobe: credit LoadTime to bay LoadBay this cycle.
REQ-005 LoadBay  input  2  target bay index 0..3 for Load.
REQ-006 LoadTime  input  12  purchased time units to credit.
REQ-007 Grant  output  4  one-hot active bay; 4'b0000 when no bay is charging.
REQ-008 Busy  output  1  high while in CHARGE.
REQ-009 PresentTime  output  12  remaining time of the granted bay; 0 when Grant is 0.
REQ-010 Done  output  4  one-cycle pulse on bit n when bay n's remaining time reaches 0.

Function
REQ-011 The block SHALL hold a 12-bit remaining-time register per bay; a bay is pending when its register is nonzero.
REQ-012 On Load, the block SHALL add LoadTime to Rem[LoadBay], saturating at 4095; LoadTime=0 SHALL have no effect.
REQ-013 The FSM SHALL have states IDLE, CHARGE, RELEASE.
REQ-014 IDLE: Grant=0; if any bay is pending, next state is CHARGE with Grant set one cycle later to the first pending bay after LastBay in round-robin order (LastBay+1, +2, +3, LastBay).
REQ-015 Pending status in IDLE SHALL be evaluated on register contents, so a Load in cycle N makes Grant valid in cycle N+2.
REQ-016 CHARGE: each Tick SHALL decrement Rem of the granted bay by 1.
REQ-017 The Tick that takes Rem from 1 to 0 SHALL cause Done[bay]=1 for exactly the next cycle, with a transition to RELEASE.
REQ-018 On entering RELEASE, LastBay SHALL be updated to the granted bay.
REQ-019 RELEASE SHALL last exactly one cycle with Grant=0 and Busy=0, then go to IDLE.
REQ-020 Minimum bay-to-bay gap: the cycle after Done is RELEASE, then IDLE, then the new Grant.
REQ-021 When Load and Tick hit the active bay in the same cycle, the result SHALL be Rem+LoadTime-1, saturated at 4095 before the decrement; no Done is issued unless the result is 0.
REQ-022 Loads to non-granted bays SHALL be accepted in every state without disturbing the active session.
REQ-023 PresentTime SHALL be a registered copy of Rem[granted bay], updated in the same cycle as Rem.
REQ-024 Grant SHALL never have more than one bit set.
REQ-025 Done SHALL never assert for a bay that was not granted.

Reset
REQ-026 Reset=1 at a rising edge SHALL clear all Rem registers and set state=IDLE, Grant=0, Busy=0, Done=0, PresentTime=0, and LastBay=3, so bay 0 has first priority.
REQ-027 Reset SHALL take priority over Load and Tick in the same cycle, including mid-session; credited time is discarded.

Configuration
REQ-028 With macro CHARGE_TIMESLICE_EN defined, the block SHALL include a 6-bit slice counter, cleared on each Grant and incremented per Tick in CHARGE.
REQ-029 With CHARGE_TIMESLICE_EN defined, the Tick that reaches 60 slice ticks with Rem still nonzero SHALL cause a transition to RELEASE without Done; Rem is retained and LastBay is updated, so other bays are served first.
REQ-030 With CHARGE_TIMESLICE_EN defined, if the slice limit and Rem=0 coincide, Done SHALL take precedence.
REQ-031 Without CHARGE_TIMESLICE_EN, there SHALL be no slice counter and each session SHALL run to completion.

Verification
REQ-032 Reset, then Load bay2 with 5, then 5 Ticks -> Grant=4'b0100 two cycles after Load; PresentTime counts 5..1; Done=4'b0100 for one cycle; Grant=0 for 2 cycles.
REQ-033 Load bays 0,1,3 with 3 each in one burst -> service order 0,1,3; 3 Done pulses; Grant is never multi-hot.
REQ-034 Load bay1 with 4000, then Load bay1 with 200 -> Rem[1]=4095 (saturated).
REQ-035 Active bay0 with Rem=1; same cycle Load bay0 with 10 and Tick -> Rem=10; no Done.
REQ-036 Reset asserted mid-CHARGE with Rem=7 -> next cycle all outputs 0 and state IDLE; no Done.
REQ-037 With CHARGE_TIMESLICE_EN: bay0=100 and bay1=5 -> bay0 released after 60 Ticks with Rem=40; bay1 served and Done; bay0 resumes and Done after 40 more Ticks.

Source files
------------

// File: rtl/charge_bay_arbiter.sv
// Four-bay charge-time arbiter: per-bay credit, round-robin service, one bay at a time.
// Optional macro CHARGE_TIMESLICE_EN caps each session at 60 ticks before yielding.
module charge_bay_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [1:0]  load_bay,
  input  logic [11:0] load_time,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [11:0] present_time,
  output logic [3:0]  done
);

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    RELEASE
  } state_t;

  state_t      state, state_nx;
  logic [11:0] rem    [4];
  logic [11:0] rem_nx [4];
  logic [1:0]  idx, idx_nx;
  logic [1:0]  last_bay, last_nx;
  logic [3:0]  done_nx;
  logic [11:0] pt_nx;
  logic        pick_ok;
  logic [1:0]  pick;

`ifdef CHARGE_TIMESLICE_EN
  logic [5:0]  slice, slice_nx;
`endif

  function automatic logic [11:0] sat_add(
    input logic [11:0] a,
    input logic [11:0] b
  );
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hfff : s[11:0];
  endfunction

  // Saturate the credit first, then take the tick off the active bay.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rem_nx[i] = rem[i];
      if (load && load_bay == 2'(i))
        rem_nx[i] = sat_add(rem[i], load_time);
      if (state == CHARGE && tick && idx == 2'(i)
          && rem_nx[i] != 12'd0)
        rem_nx[i] = rem_nx[i] - 12'd1;
    end
  end

  always_comb begin
    pick_ok = 1'b0;
    pick    = last_bay;
    for (int k = 1; k <= 4; k++) begin
      if (!pick_ok && rem[last_bay + 2'(k)] != 12'd0) begin
        pick_ok = 1'b1;
        pick    = last_bay + 2'(k);
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    last_nx  = last_bay;
    done_nx  = 4'b0000;
`ifdef CHARGE_TIMESLICE_EN
    slice_nx = slice;
`endif
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nx = CHARGE;
          idx_nx   = pick;
`ifdef CHARGE_TIMESLICE_EN
          slice_nx = 6'd0;
`endif
        end
      end
      CHARGE: begin
        if (tick) begin
`ifdef CHARGE_TIMESLICE_EN
          slice_nx = slice + 6'd1;
`endif
          if (rem_nx[idx] == 12'd0) begin
            state_nx = RELEASE;
            last_nx  = idx;
            done_nx  = 4'b0001 << idx;
          end
`ifdef CHARGE_TIMESLICE_EN
          else if (slice == 6'd59) begin
            state_nx = RELEASE;
            last_nx  = idx;
          end
`endif
        end
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    pt_nx = (state_nx == CHARGE) ? rem_nx[idx_nx] : 12'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 2'd0;
      last_bay     <= 2'd3;
      done         <= 4'b0000;
      present_time <= 12'd0;
      for (int i = 0; i < 4; i++)
        rem[i] <= 12'd0;
`ifdef CHARGE_TIMESLICE_EN
      slice        <= 6'd0;
`endif
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      last_bay     <= last_nx;
      done         <= done_nx;
      present_time <= pt_nx;
      for (int i = 0; i < 4; i++)
        rem[i] <= rem_nx[i];
`ifdef CHARGE_TIMESLICE_EN
      slice        <= slice_nx;
`endif
    end
  end

  assign busy  = (state == CHARGE);
  assign grant = busy ? (4'b0001 << idx) : 4'b0000;

endmodule
